lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that drives the core's data-memory port: `addr_mem`, `w_data_mem`, `w_en_mem` and `en_mem` out, `r_data_mem` in. It accepts one load or store at a time from the MEM stage over a valid/ready handshake. It converts the request into byte-laned word accesses, splitting word-crossing misaligned accesses into two beats. Load data is merged, shifted and sign- or zero-extended, and a registered response is returned to writeback. The memory on the other end is a synchronous-read, byte-write-enable, word-addressed RAM of `RAM_SPACE` words: it decodes address bits `[log2(RAM_SPACE)+1:2]`, and read data appears the cycle after `en_mem`.

## Interface
- `RAM_SPACE`, default 4096: memory depth in 32-bit words; sets the legal address range.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is illegal and treated as an error.
- `req_unsigned` in 1: zero-extend load data (LBU/LHU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_rd` in 5: destination tag, echoed on the response.
- `rsp_valid` out 1: one-cycle completion pulse; there is no back-pressure.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_rd` out 5: echoed tag.
- `rsp_err` out 1: out-of-range address or illegal size.
- `addr_mem` out 32: byte address of the current beat, word-aligned (bits `[1:0]` = 0).
- `w_data_mem` out 32: lane-shifted store data.
- `w_en_mem` out 4: byte write enables; 0 for reads.
- `en_mem` out 1: memory access strobe, active high.
- `r_data_mem` in 32: memory read data, valid the cycle after `en_mem`.

## Operation
Address decode:
- `off = req_addr[1:0]`, `wa = req_addr[31:2]`, `nbytes` = 1, 2 or 4.
- Split when `off + nbytes > 4`. Split cases are a half at off 3 and a word at off 1, 2 or 3.
- A half at off 1 is a single beat.
- Error when `wa` (or `wa+1` if split) ≥ `RAM_SPACE`, when `req_addr[31:2+log2(RAM_SPACE)]` ≠ 0, or when size is 11.
- An errored request makes no memory access. There is no wrap-around to word 0.

Stores:
- Lane mask `m = (1,3,F by size) << off`, taken as 8 bits.
- Data `d = req_wdata << 8*off`, taken as 64 bits.
- Beat0: `w_en_mem = m[3:0]`, `w_data_mem = d[31:0]`.
- Beat1, at `wa+1`: `w_en_mem = m[7:4]`, `w_data_mem = d[63:32]`.

Loads:
- Beat0 data is captured into register `lo`. Beat1 data, or 0 if there is no split, forms `hi`.
- Result `r = {hi,lo} >> 8*off`; the low `nbytes` are kept and then extended per `req_unsigned`.

State machine:
- IDLE: `req_ready` = 1.
  - On `req_valid`, latch the request. Go to ERR if it errors, else to BEAT0.
- BEAT0: drive beat0 with `en_mem` = 1.
  - If split, go to BEAT1.
  - Else, a store goes to DONE and a load goes to LWAIT.
- BEAT1: drive beat1 with `en_mem` = 1. Capture beat0 read data into `lo`.
  - A store goes to DONE; a load goes to LWAIT.
- LWAIT: `en_mem` = 0. Capture the last beat's read data and merge it.
  - Go to DONE.
- DONE and ERR: the registered response pulses for one cycle; ERR sets `rsp_err` = 1.
  - Go to IDLE.

Port driving:
- Memory port outputs are registered and are 0 (`w_en_mem` = 0, `en_mem` = 0) outside BEAT0/BEAT1.
- Requests arriving while `req_ready` = 0 are held off by the handshake and never dropped.

## Timing
Latency, with the request accepted at edge N:
- Single-beat store: `en_mem` high in cycle N+1; `rsp_valid` in N+2.
- Single-beat load: `en_mem` in N+1; data in N+2; `rsp_valid` in N+3.
- Split store: `en_mem` in N+1 and N+2; `rsp_valid` in N+3.
- Split load: `en_mem` in N+1 and N+2; `rsp_valid` in N+4.
- Error: `rsp_valid` with `rsp_err` = 1 in N+2; no `en_mem`.

Throughput and response:
- `req_ready` re-asserts in the cycle after `rsp_valid`. Back-to-back requests are never overlapped.
- `rsp_rdata`, `rsp_rd` and `rsp_err` are held until the next response; they are only meaningful with `rsp_valid`.

Reset:
- Reset values: `rsp_valid`, `rsp_rdata`, `rsp_rd`, `rsp_err`, `addr_mem`, `w_data_mem`, `w_en_mem` and `en_mem` are all 0; state is IDLE, so `req_ready` = 1.
- `rstn` low mid-operation forces IDLE and zeroes the memory port asynchronously. Any partially written split store stays partial, and no response is issued.

## Structure
- Size encodings (`SIZE_B/H/W`) and state encodings go in `define.v`, next to the existing core constants.
- The lane shift, mask generation and extension form one natural combinational sub-module, `lsu_align`, used for both the store path and the load merge.
- The top level holds the FSM, the request latch, `lo`, and the response registers.

## Test plan
- Reset, then a word store of 0xDEADBEEF to address 0x10 → `en_mem` in N+1 with `addr_mem`=0x10, `w_en_mem`=F, `w_data_mem`=0xDEADBEEF; `rsp_valid` in N+2.
- LB then LBU at 0x13, with memory word 4 = 0x80FF1234 → `rsp_rdata` = 0xFFFFFF80, then 0x00000080, each 3 cycles after accept.
- Split word store of 0x11223344 at 0x21 → beat0 at 0x20 with mask E and data 0x22334400; beat1 at 0x24 with mask 1 and data 0x00000011. A split word load back from 0x21 returns 0x11223344 in N+4.
- Half load at 0x1B, with word 6 = 0xAB000000 and word 7 = 0x000000CD → `rsp_rdata` = 0xFFFFCDAB, split over two beats.
- Load at 0x00004000 with `RAM_SPACE`=4096 → no `en_mem`, `rsp_err`=1 and `rsp_rdata`=0 in N+2. Size 11 gives the same response.
- `rstn` pulsed low during BEAT1 of a split store → `en_mem` drops immediately, no `rsp_valid`, and `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared constants and types for the load/store memory master:
// access sizes, FSM state codes and the latched request record.
package lsu_mem_master_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BEAT0 = 3'd1;
    localparam logic [2:0] ST_BEAT1 = 3'd2;
    localparam logic [2:0] ST_LWAIT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [29:0] wa;
        logic [1:0]  off;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        split;
    } lsu_req_t;

    // Access width in bytes; 0 for the illegal encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask/data shifted onto a two-word window,
// and load data extracted from a two-word window then extended.
module lsu_align
    import lsu_mem_master_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rraw_i,
    output logic [7:0]  mask_o,
    output logic [63:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [3:0]  base;
    logic [31:0] shifted;

    always_comb begin
        case (size_i)
            SIZE_B:  base = 4'h1;
            SIZE_H:  base = 4'h3;
            SIZE_W:  base = 4'hF;
            default: base = 4'h0;
        endcase
        mask_o  = {4'h0, base} << off_i;
        wdata_o = {32'h0, wdata_i} << {off_i, 3'b000};
        shifted = 32'(rraw_i >> {off_i, 3'b000});
        case (size_i)
            SIZE_B:  rdata_o = uns_i ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  rdata_o = uns_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// One-at-a-time load/store initiator for a synchronous byte-write word RAM.
// Misaligned word-crossing accesses are issued as two consecutive beats.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int RAM_SPACE = 4096
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic [31:0] addr_mem,
    output logic [31:0] w_data_mem,
    output logic [3:0]  w_en_mem,
    output logic        en_mem,
    input  logic [31:0] r_data_mem
);

    logic [2:0]  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [31:0] lo_q, lo_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic [31:0] addr_q, addr_d, wdat_q, wdat_d;
    logic [3:0]  wen_q, wen_d;
    logic        en_q, en_d;

    logic [2:0]  in_nb;
    logic        in_split, in_err, idle;
    logic [30:0] in_last;
    logic [1:0]  a_size, a_off;
    logic [31:0] a_wdata, a_rdata;
    logic [63:0] a_raw, a_wd;
    logic [7:0]  a_mask;

    // Wide compare on the last touched word covers both the depth limit
    // and any set upper address bits; no wrap-around to word 0.
    assign in_nb    = size_bytes(req_size);
    assign in_split = (3'(req_addr[1:0]) + in_nb) > 3'd4;
    assign in_last  = {1'b0, req_addr[31:2]} + 31'(in_split);
    assign in_err   = (req_size == 2'b11) || (in_last >= 31'(RAM_SPACE));

    // Beat0 is registered straight from the request, so the aligner
    // looks at the live inputs in IDLE and at the latched copy afterwards.
    assign idle    = (state_q == ST_IDLE);
    assign a_size  = idle ? req_size       : req_q.size;
    assign a_off   = idle ? req_addr[1:0]  : req_q.off;
    assign a_wdata = idle ? req_wdata      : req_q.wdata;
    assign a_raw   = req_q.split ? {r_data_mem, lo_q} : {32'h0, r_data_mem};

    lsu_align u_align (
        .size_i  (a_size),
        .off_i   (a_off),
        .uns_i   (req_q.uns),
        .wdata_i (a_wdata),
        .rraw_i  (a_raw),
        .mask_o  (a_mask),
        .wdata_o (a_wd),
        .rdata_o (a_rdata)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        lo_d        = lo_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        addr_d      = 32'h0;
        wdat_d      = 32'h0;
        wen_d       = 4'h0;
        en_d        = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                req_d = '{we: req_we, size: req_size, uns: req_unsigned, wa: req_addr[31:2],
                          off: req_addr[1:0], wdata: req_wdata, rd: req_rd, split: in_split};
                if (in_err) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_BEAT0;
                    en_d    = 1'b1;
                    addr_d  = {req_addr[31:2], 2'b00};
                    wen_d   = req_we ? a_mask[3:0] : 4'h0;
                    wdat_d  = req_we ? a_wd[31:0]  : 32'h0;
                end
            end
            ST_BEAT0: begin
                if (req_q.split) begin
                    state_d = ST_BEAT1;
                    en_d    = 1'b1;
                    addr_d  = {req_q.wa + 30'd1, 2'b00};
                    wen_d   = req_q.we ? a_mask[7:4] : 4'h0;
                    wdat_d  = req_q.we ? a_wd[63:32] : 32'h0;
                end else if (req_q.we) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_rd_d    = req_q.rd;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = ST_LWAIT;
                end
            end
            ST_BEAT1: begin
                lo_d = r_data_mem;
                if (req_q.we) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_rd_d    = req_q.rd;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = ST_LWAIT;
                end
            end
            ST_LWAIT: begin
                state_d     = ST_DONE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = a_rdata;
                rsp_rd_d    = req_q.rd;
                rsp_err_d   = 1'b0;
            end
            ST_ERR: begin
                state_d     = ST_DONE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'h0;
                rsp_rd_d    = req_q.rd;
                rsp_err_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            lo_q        <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_rd_q    <= 5'h0;
            rsp_err_q   <= 1'b0;
            addr_q      <= 32'h0;
            wdat_q      <= 32'h0;
            wen_q       <= 4'h0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            wen_q       <= wen_d;
            en_q        <= en_d;
        end
    end

    assign req_ready  = idle;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_rd     = rsp_rd_q;
    assign rsp_err    = rsp_err_q;
    assign addr_mem   = addr_q;
    assign w_data_mem = wdat_q;
    assign w_en_mem   = wen_q;
    assign en_mem     = en_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-array reference memory, directed cases
// from the block's examples, an async reset mid split store, then random traffic.
module tb_lsu_mem_master;

    localparam int RAM_SPACE = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'h0;
    logic        req_ready, rsp_valid, rsp_err, en_mem;
    logic [31:0] rsp_rdata, addr_mem, w_data_mem;
    logic [4:0]  rsp_rd;
    logic [3:0]  w_en_mem;
    logic [31:0] r_data_mem = 32'h0;

    bit [31:0] ram [RAM_SPACE];
    bit [7:0]  ref_b [RAM_SPACE*4];

    int nvec = 0, nerr = 0;
    logic [31:0] b_addr [2], b_data [2];
    logic [3:0]  b_wen [2];
    int          b_cyc [2];
    logic [31:0] last_rdata;
    logic        last_err;

    lsu_mem_master #(.RAM_SPACE(RAM_SPACE)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .addr_mem(addr_mem), .w_data_mem(w_data_mem), .w_en_mem(w_en_mem),
        .en_mem(en_mem), .r_data_mem(r_data_mem)
    );

    always #5 clk = ~clk;

    // Synchronous-read, byte-write RAM on the far side of the port.
    always @(posedge clk) begin
        if (en_mem) begin
            for (int l = 0; l < 4; l++)
                if (w_en_mem[l]) ram[addr_mem[13:2]][l*8 +: 8] <= w_data_mem[l*8 +: 8];
            r_data_mem <= ram[addr_mem[13:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    // Reference: byte-addressed memory, response value, latency and beat count.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit err, output logic [31:0] rdata, output int lat, output int beats);
        int nb = nbytes(sz);
        longint last;
        bit split;
        longint v;
        err = (sz == 2'd3);
        if (!err) begin
            last = longint'(a) + nb - 1;
            err  = (last >> 2) >= RAM_SPACE;
        end
        split = !err && ((a & 32'd3) + nb > 4);
        rdata = 32'h0;
        if (err) begin
            lat = 2; beats = 0;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_b[a + i] = wd[8*i +: 8];
            lat = split ? 3 : 2; beats = split ? 2 : 1;
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(ref_b[a + i]) << (8*i));
            if (!uns && v[8*nb-1]) v = v | ~((longint'(1) << (8*nb)) - 1);
            rdata = v[31:0];
            lat = split ? 4 : 3; beats = split ? 2 : 1;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        int lat = 0, beats = 0, exp_lat, exp_beats, wc = 0, nb;
        bit exp_err;
        logic [31:0] exp_rdata, dm;
        logic [3:0]  e_wen [2];
        logic [31:0] e_data [2];
        logic [31:0] got_data = 32'h0;
        logic [4:0]  got_rd = 5'h0;
        logic        got_err = 1'b0;
        longint ba;
        nb = nbytes(sz);
        for (int j = 0; j < 2; j++) begin
            e_wen[j] = 4'h0; e_data[j] = 32'h0;
            for (int l = 0; l < 4; l++) begin
                ba = (((longint'(a) >> 2) + j) << 2) + l;
                if (ba >= longint'(a) && ba < longint'(a) + nb) begin
                    e_wen[j][l] = 1'b1;
                    e_data[j][8*l +: 8] = wd[8*int'(ba - longint'(a)) +: 8];
                end
            end
        end
        model(we, sz, uns, a, wd, exp_err, exp_rdata, exp_lat, exp_beats);
        @(negedge clk);
        while (!req_ready && wc < 16) begin @(negedge clk); wc++; end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (en_mem) begin
                if (beats < 2) begin
                    b_addr[beats] = addr_mem; b_wen[beats] = w_en_mem;
                    b_data[beats] = w_data_mem; b_cyc[beats] = c;
                end
                beats++;
            end
            if (rsp_valid) begin
                lat = c; got_data = rsp_rdata; got_rd = rsp_rd; got_err = rsp_err;
            end
        end
        last_rdata = got_data; last_err = got_err;
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err", 32'(got_err), 32'(exp_err));
        chk("rsp_rdata", got_data, exp_rdata);
        chk("rsp_rd", 32'(got_rd), 32'(rd));
        chk("mem_beats", 32'(beats), 32'(exp_beats));
        for (int j = 0; j < 2 && j < beats && j < exp_beats; j++) begin
            chk("beat_addr", b_addr[j], 32'((((longint'(a) >> 2) + j) << 2)));
            chk("beat_cycle", 32'(b_cyc[j]), 32'(j + 1));
            chk("beat_wen", 32'(b_wen[j]), we ? 32'(e_wen[j]) : 32'h0);
            if (we) begin
                dm = {{8{e_wen[j][3]}}, {8{e_wen[j][2]}}, {8{e_wen[j][1]}}, {8{e_wen[j][0]}}};
                chk("beat_wdata", b_data[j] & dm, e_data[j]);
            end
        end
        @(negedge clk);
        chk("rsp_one_pulse", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_en_mem", 32'(en_mem), 32'd0);
        chk("reset_addr", addr_mem, 32'h0);
        chk("reset_wen", 32'(w_en_mem), 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        rstn = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1);
        chk("sw_addr", b_addr[0], 32'h10);
        chk("sw_wen", 32'(b_wen[0]), 32'hF);
        chk("sw_wdata", b_data[0], 32'hDEADBEEF);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF1234, 5'd2);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd3);
        chk("lb_value", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd4);
        chk("lbu_value", last_rdata, 32'h00000080);

        do_req(1'b1, 2'd2, 1'b0, 32'h21, 32'h11223344, 5'd5);
        chk("split_sw_b0_addr", b_addr[0], 32'h20);
        chk("split_sw_b0_wen", 32'(b_wen[0]), 32'hE);
        chk("split_sw_b0_data", b_data[0], 32'h22334400);
        chk("split_sw_b1_addr", b_addr[1], 32'h24);
        chk("split_sw_b1_wen", 32'(b_wen[1]), 32'h1);
        chk("split_sw_b1_data", b_data[1], 32'h00000011);
        do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 5'd6);
        chk("split_lw_value", last_rdata, 32'h11223344);

        do_req(1'b1, 2'd2, 1'b0, 32'h18, 32'hAB000000, 5'd7);
        do_req(1'b1, 2'd2, 1'b0, 32'h1C, 32'h000000CD, 5'd8);
        do_req(1'b0, 2'd1, 1'b0, 32'h1B, 32'h0, 5'd9);
        chk("split_lh_value", last_rdata, 32'hFFFFCDAB);

        do_req(1'b0, 2'd2, 1'b0, 32'h00004000, 32'h0, 5'd10);
        chk("oob_err", 32'(last_err), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd11);
        chk("size11_err", 32'(last_err), 32'd1);
        do_req(1'b0, 2'd1, 1'b0, 32'h3FFF, 32'h0, 5'd12);
        chk("top_split_err", 32'(last_err), 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hCAFEF00D, 5'd13);
        do_req(1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, 5'd14);
        chk("top_word_value", last_rdata, 32'hCAFEF00D);

        // Reset during beat1 of a split store: beat0 lanes stay written.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h41; req_wdata = 32'hA5A5A5A5; req_rd = 5'd15;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 chk("rst_beat1_en", 32'(en_mem), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_en_drop", 32'(en_mem), 32'd0);
        chk("rst_wen_drop", 32'(w_en_mem), 32'd0);
        chk("rst_addr_drop", addr_mem, 32'h0);
        for (int i = 1; i < 4; i++) ref_b[32'h40 + i] = 8'hA5;
        @(negedge clk);
        rstn = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) quiet = 1'b0;
        end
        chk("rst_no_rsp", 32'(quiet), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd16);
        do_req(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 5'd17);

        for (int n = 0; n < 300; n++) begin
            int sel = int'($urandom_range(0, 9));
            logic [31:0] a;
            logic [1:0]  sz;
            if (sel == 0)      a = 32'h3FF0 + $urandom_range(0, 31);
            else if (sel == 1) a = $urandom;
            else               a = $urandom_range(0, 255);
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
